// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl
//   Parallel-to-serial controller. Accepts an N-bit word on a valid/ready
//   handshake, then presents it one bit per cycle on ser_out_o, MSB-first or
//   LSB-first as chosen by dir_i at acceptance. hold_i pauses shifting. A
//   one-cycle done pulse follows the last bit, then the controller is idle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset (priority over all inputs)
//   in_data_i    parallel word to serialize
//   in_valid_i   in_data_i is valid
//   in_ready_o   controller can accept a word (idle)
//   dir_i        shift order: 0 = MSB first, 1 = LSB first
//   hold_i       freezes shifting while high (only acts while shifting)
//   ser_out_o    current serial bit
//   ser_valid_o  ser_out_o carries a valid bit this cycle
//   busy_o       word in flight or done cycle in progress
//   done_o       one-cycle pulse after the last bit
//   bit_cnt_o    index of the bit presented, 0-based in shift order

module shift_reg_ctrl #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 dir_i,
  input  logic                 hold_i,
  output logic                 ser_out_o,
  output logic                 ser_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(N)-1:0] bit_cnt_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic           dir_q,   dir_d;
  logic [CW-1:0]  cnt_q,   cnt_d;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    ser_out_o   = 1'b0;
    ser_valid_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    bit_cnt_o   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          shreg_d = in_data_i;
          dir_d   = dir_i;
          cnt_d   = CNT_ZERO;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        busy_o      = 1'b1;
        ser_valid_o = ~hold_i;
        // The output end is fixed by the direction captured at acceptance.
        ser_out_o   = dir_q ? shreg_q[0] : shreg_q[N-1];
        if (hold_i) begin
          state_d = ST_SHIFT;
        end else if (cnt_q == CNT_LAST) begin
          // Last bit presented: leave register and count where they are.
          state_d = ST_DONE;
        end else begin
          if (dir_q) begin
            shreg_d = {1'b0, shreg_q[N-1:1]};
          end else begin
            shreg_d = {shreg_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        // Clear the count here so the idle state always shows index 0.
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

endmodule
